// File: rtl/mem_port_arbiter.sv
// Arbitrates one handshake-driven single-port memory between instruction fetch and the MEM stage.
// Optional starvation guard for fetch is enabled by defining MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_gnt_o,
  output logic              mem_rvalid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stall_o,
  output logic              port_req_o,
  output logic              port_we_o,
  output logic [ADDR_W-1:0] port_addr_o,
  output logic [DATA_W-1:0] port_wdata_o,
  input  logic              port_ack_i,
  input  logic [DATA_W-1:0] port_rdata_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic ifElig;
  logic memElig;
  logic issueIf;
  logic issueMem;
  logic preferIf;

  if (STREAK_MAX < 1) begin : gStreakCheck
    $error("STREAK_MAX must be at least 1");
  end

  // A requester in its rvalid cycle still shows the finished transfer on req_i.
  assign ifElig      = if_req_i & ~if_rvalid_o;
  assign memElig     = mem_req_i & ~mem_rvalid_o;
  assign if_stall_o  = if_req_i & ~if_rvalid_o;
  assign mem_stall_o = mem_req_i & ~mem_rvalid_o;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STREAK_MAX + 1);

  logic [CNT_W-1:0] streakCnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streakCnt <= '0;
    end else if (!if_req_i || issueIf) begin
      streakCnt <= '0;
    end else if (issueMem && (streakCnt < CNT_W'(STREAK_MAX))) begin
      streakCnt <= streakCnt + 1'b1;
    end
  end

  assign preferIf = (streakCnt == CNT_W'(STREAK_MAX));
`else
  assign preferIf = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (issueMem) begin
          stateNext = BUSY_MEM;
        end else if (issueIf) begin
          stateNext = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (port_ack_i) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // MEM holds the older instruction, so it wins unless the guard hands the slot to IF.
  always_comb begin
    issueIf  = 1'b0;
    issueMem = 1'b0;
    if (state == IDLE) begin
      if (memElig && !(ifElig && preferIf)) begin
        issueMem = 1'b1;
      end else if (ifElig) begin
        issueIf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_gnt_o     <= 1'b0;
      mem_gnt_o    <= 1'b0;
      if_rvalid_o  <= 1'b0;
      mem_rvalid_o <= 1'b0;
      port_req_o   <= 1'b0;
      port_we_o    <= 1'b0;
      port_addr_o  <= '0;
      port_wdata_o <= '0;
      if_rdata_o   <= '0;
      mem_rdata_o  <= '0;
    end else begin
      if_gnt_o     <= issueIf;
      mem_gnt_o    <= issueMem;
      if_rvalid_o  <= (state == BUSY_IF) & port_ack_i;
      mem_rvalid_o <= (state == BUSY_MEM) & port_ack_i;
      if (issueMem) begin
        port_req_o   <= 1'b1;
        port_we_o    <= mem_we_i;
        port_addr_o  <= mem_addr_i;
        port_wdata_o <= mem_wdata_i;
      end else if (issueIf) begin
        port_req_o  <= 1'b1;
        port_we_o   <= 1'b0;
        port_addr_o <= if_addr_i;
      end else if ((state != IDLE) && port_ack_i) begin
        port_req_o <= 1'b0;
      end
      if ((state == BUSY_IF) && port_ack_i) begin
        if_rdata_o <= port_rdata_i;
      end
      if ((state == BUSY_MEM) && port_ack_i && !port_we_o) begin
        mem_rdata_o <= port_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: pipeline-like requesters, a latency-randomized memory,
// and a transfer-level reference model checked every cycle.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STREAK_MAX = 4;
  localparam int N_CYCLES   = 4000;

  logic              clk;
  logic              rst;
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifGnt;
  logic              ifRvalid;
  logic [DATA_W-1:0] ifRdata;
  logic              ifStall;
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memGnt;
  logic              memRvalid;
  logic [DATA_W-1:0] memRdata;
  logic              memStall;
  logic              portReq;
  logic              portWe;
  logic [ADDR_W-1:0] portAddr;
  logic [DATA_W-1:0] portWdata;
  logic              portAck;
  logic [DATA_W-1:0] portRdata;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (ifReq),
    .if_addr_i   (ifAddr),
    .if_gnt_o    (ifGnt),
    .if_rvalid_o (ifRvalid),
    .if_rdata_o  (ifRdata),
    .if_stall_o  (ifStall),
    .mem_req_i   (memReq),
    .mem_we_i    (memWe),
    .mem_addr_i  (memAddr),
    .mem_wdata_i (memWdata),
    .mem_gnt_o   (memGnt),
    .mem_rvalid_o(memRvalid),
    .mem_rdata_o (memRdata),
    .mem_stall_o (memStall),
    .port_req_o  (portReq),
    .port_we_o   (portWe),
    .port_addr_o (portAddr),
    .port_wdata_o(portWdata),
    .port_ack_i  (portAck),
    .port_rdata_i(portRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which side owns the single outstanding transfer, and what the outputs must be.
  typedef struct {
    int                who;   // 0 none, 1 fetch, 2 data
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  xfer_t             cur;
  logic [DATA_W-1:0] memArr [0:7];
  int                lat;
  int                streak;
  logic              eIfGnt, eMemGnt, eIfRvalid, eMemRvalid, ePortReq, ePortWe;
  logic [ADDR_W-1:0] ePortAddr;
  logic [DATA_W-1:0] ePortWdata, eIfRdata, eMemRdata;

  function automatic logic [ADDR_W-1:0] randAddr();
    return ADDR_W'($urandom_range(0, 7) * 4);
  endfunction

  task automatic modelReset();
    cur.who = 0; cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
    streak = 0;
    eIfGnt = 0; eMemGnt = 0; eIfRvalid = 0; eMemRvalid = 0; ePortReq = 0; ePortWe = 0;
    ePortAddr = '0; ePortWdata = '0; eIfRdata = '0; eMemRdata = '0;
  endtask

  task automatic modelStep();
    logic ifEl, memEl, starveDue, pickIf, pickMem, nIfRv, nMemRv;
    if (rst) begin
      modelReset();
      return;
    end
    ifEl  = ifReq && !eIfRvalid;
    memEl = memReq && !eMemRvalid;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    starveDue = (streak == STREAK_MAX);
`else
    starveDue = 1'b0;
`endif
    pickIf = 0; pickMem = 0; nIfRv = 0; nMemRv = 0;
    if (cur.who == 0) begin
      pickIf  = ifEl && (!memEl || starveDue);
      pickMem = memEl && !pickIf;
      if (pickMem) begin
        cur.who = 2; cur.we = memWe; cur.addr = memAddr; cur.wdata = memWdata;
      end else if (pickIf) begin
        cur.who = 1; cur.we = 1'b0; cur.addr = ifAddr;
      end
      if (pickMem || pickIf) begin
        ePortReq = 1; ePortWe = cur.we; ePortAddr = cur.addr; ePortWdata = cur.wdata;
        lat = $urandom_range(0, 3);
      end
    end else if (portAck) begin
      if (cur.who == 1) begin
        nIfRv = 1; eIfRdata = portRdata;
      end else begin
        nMemRv = 1;
        if (!cur.we) eMemRdata = portRdata;
      end
      cur.who  = 0;
      ePortReq = 0;
    end
    if (!ifReq || pickIf) streak = 0;
    else if (pickMem && streak < STREAK_MAX) streak++;
    eIfGnt = pickIf; eMemGnt = pickMem; eIfRvalid = nIfRv; eMemRvalid = nMemRv;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) memArr[i] = $urandom;
    modelReset();
    lat = 0;
    rst = 1; ifReq = 0; ifAddr = '0; memReq = 0; memWe = 0; memAddr = '0; memWdata = '0;
    portAck = 0; portRdata = '0;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      checkVal("if_gnt", 32'(ifGnt), 32'(eIfGnt));
      checkVal("mem_gnt", 32'(memGnt), 32'(eMemGnt));
      checkVal("if_rvalid", 32'(ifRvalid), 32'(eIfRvalid));
      checkVal("mem_rvalid", 32'(memRvalid), 32'(eMemRvalid));
      checkVal("if_rdata", ifRdata, eIfRdata);
      checkVal("mem_rdata", memRdata, eMemRdata);
      checkVal("port_req", 32'(portReq), 32'(ePortReq));
      checkVal("port_we", 32'(portWe), 32'(ePortWe));
      checkVal("port_addr", portAddr, ePortAddr);
      checkVal("port_wdata", portWdata, ePortWdata);

      rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
      // Requesters behave like pipeline stages: hold until rvalid, then drop or reissue at once.
      if (ifReq && eIfRvalid) begin
        if ($urandom_range(0, 1) == 0) ifReq = 0;
        else ifAddr = randAddr();
      end else if (!ifReq && $urandom_range(0, 2) == 0) begin
        ifReq = 1; ifAddr = randAddr();
      end
      if (memReq && eMemRvalid) begin
        if ($urandom_range(0, 2) == 0) memReq = 0;
        else begin
          memWe = 1'($urandom_range(0, 1)); memAddr = randAddr(); memWdata = $urandom;
        end
      end else if (!memReq && $urandom_range(0, 1) == 0) begin
        memReq = 1; memWe = 1'($urandom_range(0, 1)); memAddr = randAddr(); memWdata = $urandom;
      end
      // Memory: ack after a random latency; stray acks while nothing is outstanding.
      if (cur.who != 0) begin
        if (lat == 0) begin
          portAck = 1;
          if (cur.we) begin
            portRdata = $urandom;
            memArr[cur.addr[4:2]] = cur.wdata;
          end else begin
            portRdata = memArr[cur.addr[4:2]];
          end
        end else begin
          portAck = 0; portRdata = $urandom; lat--;
        end
      end else begin
        portAck = ($urandom_range(0, 7) == 0); portRdata = $urandom;
      end

      #1;
      checkVal("if_stall", 32'(ifStall), 32'(ifReq && !eIfRvalid));
      checkVal("mem_stall", 32'(memStall), 32'(memReq && !eMemRvalid));
      modelStep();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, handshake-driven memory between the instruction-fetch stage and the MEM stage of the pipelined CPU, so that the design can run from a unified memory. It grants one requester at a time, holds the memory request until the memory acknowledges, and returns read data or write completion to the granted side. It also produces per-stage stall signals; the pipeline hazard logic ORs these into PC/IF_ID hold and bubble insertion.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STREAK_MAX, 4, maximum consecutive MEM grants while IF is waiting (used only with the starvation guard)

Ports:
- clk_i  in  1  clock, all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request, held until if_rvalid_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i is high
- if_gnt_o  out  1  one-cycle pulse when the fetch is issued to memory
- if_rvalid_o  out  1  one-cycle pulse when if_rdata_o is valid
- if_rdata_o  out  DATA_W  fetched instruction, held until the next IF completion
- if_stall_o  out  1  if_req_i & ~if_rvalid_o (combinational)
- mem_req_i  in  1  data request, held until mem_rvalid_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  write data
- mem_gnt_o  out  1  one-cycle issue pulse
- mem_rvalid_o  out  1  one-cycle completion pulse, for reads and writes
- mem_rdata_o  out  DATA_W  read data; held unchanged across writes
- mem_stall_o  out  1  mem_req_i & ~mem_rvalid_o (combinational)
- port_req_o  out  1  memory request, held until port_ack_i
- port_we_o  out  1  write enable
- port_addr_o  out  ADDR_W  address
- port_wdata_o  out  DATA_W  write data
- port_ack_i  in  1  memory done, one cycle; qualifies port_rdata_i
- port_rdata_i  in  DATA_W  read data

## Operation
- FSM states and transitions:
  - IDLE: on a clock edge, if a request is eligible, latch its addr/we/wdata into the port registers, set port_req_o=1, pulse the matching gnt, and go to BUSY_IF or BUSY_MEM.
  - BUSY_x: hold port_* stable. On the edge where port_ack_i=1, clear port_req_o, register port_rdata_i into x_rdata_o (reads only), pulse x_rvalid_o, and return to IDLE.
- Eligibility: a requester whose rvalid_o is high in the current cycle is not eligible. Its req_i still shows the completed transfer, so this rule prevents a duplicate issue.
- Priority: MEM wins over IF. The MEM stage holds the older instruction, which prevents deadlock.
- port_ack_i is ignored in IDLE.
- Only one transfer is outstanding at any time.
- Reset, at any point including mid-transfer: state=IDLE; port_req_o, port_we_o, all gnt and rvalid outputs = 0; port_addr_o, port_wdata_o, if_rdata_o, mem_rdata_o = 0; streak counter = 0. An abandoned transfer is not completed, and its late ack is ignored.

## Timing
- Request sampled at edge E: port_req_o and gnt are high from cycle E+1.
- Memory acks in cycle A (A ≥ E+1): rvalid is high and data valid in cycle A+1, and the FSM is in IDLE in A+1.
- The next issue is decided at the end of A+1, giving one dead cycle between transfers. Minimum transfer: 3 cycles, request to rvalid.
- Stall outputs are combinational, with no added latency. They fall in the rvalid cycle so the pipeline advances on that edge.

## Configuration
- Macro: MEM_PORT_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width clog2(STREAK_MAX+1) increments on each MEM grant issued while if_req_i is high.
  - It clears on an IF grant or whenever if_req_i=0.
  - When counter == STREAK_MAX and both requests are eligible, IF is granted.
- Undefined: strict MEM priority; no counter logic is generated.

## Test plan
- Single fetch: if_req_i=1 with addr 0x10, memory acks 2 cycles after port_req_o rises with rdata 0x8C010004 → if_gnt_o at cycle 1, if_rvalid_o at cycle 4, if_rdata_o=0x8C010004, if_stall_o high for cycles 0–3.
- Write then read: mem write to 0x20 with data 0xDEADBEEF, then a read of 0x20 → port_we_o=1 only for the first transfer; mem_rvalid_o pulses twice; mem_rdata_o=0xDEADBEEF only after the read.
- Simultaneous requests: if_req_i and mem_req_i asserted together, ack latency 1 → MEM issued first, IF issued in the cycle after mem_rvalid_o; no duplicate MEM issue.
- Starvation, macro defined, STREAK_MAX=4: mem_req_i held continuously and if_req_i pending → IF granted after the 4th MEM grant. With the macro undefined → IF never granted.
- Reset mid-transfer: rst_i=1 in BUSY_MEM, then ack arrives 1 cycle after reset deasserts → all outputs 0, FSM in IDLE, no rvalid pulse.
- Stray ack: port_ack_i=1 in IDLE → no rvalid pulse, no state change.
